// File: rtl/vga_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_ctrl
// Purpose  : Buffers an upstream RGB valid/ready stream in a small FIFO and
//            feeds the VGA timing core one word per active pixel, aligned to
//            the core's v_sync. Detects underflow and misplaced SOF marks and
//            recovers at the next frame boundary.
// Options  : define VGA_TEST_PATTERN_EN to add the pattern_sel input, which
//            replaces the stream with 8 vertical colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module vga_stream_ctrl #(
  parameter int                    DATA_WIDTH      = 12,
  parameter int                    FIFO_DEPTH      = 16,
  parameter int                    H_ACTIVE        = 640,
  parameter int                    V_ACTIVE        = 480,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  video_on,
  input  logic                  v_sync,
  output logic [DATA_WIDTH-1:0] data_stream,
  output logic                  frame_active,
  output logic                  underflow,
  output logic                  sync_err,
  input  logic                  err_clr
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic                  pattern_sel
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [1:0] S_WAIT_SOF = 2'd0;
  localparam logic [1:0] S_FILL     = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [1:0]            r_state, w_next_state;
  logic                  r_live;
  logic                  r_vsync_q;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [XW-1:0]         r_x, w_x_next, w_x_adv;
  logic [YW-1:0]         r_y, w_y_next, w_y_adv;
  logic [DATA_WIDTH-1:0] r_data, w_data_next, w_bar;
  logic                  r_frame_active, r_underflow, r_sync_err;
  logic                  w_pat, w_full, w_empty, w_ready, w_hs;
  logic                  w_vs_rise, w_vs_fall, w_x_last, w_y_last, w_first_pix;
  logic                  w_push, w_pop, w_flush, w_set_uf, w_set_se;
  logic [EW-1:0]         w_head, w_push_word;
  logic [2:0]            w_bar_idx;

  // Colour bar table, left to right.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  assign w_pat = pattern_sel;
`else
  assign w_pat = 1'b0;
`endif

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_vs_rise   = v_sync & ~r_vsync_q;
  assign w_vs_fall   = ~v_sync & r_vsync_q;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_push_word = {s_sof, s_data};
  assign w_x_last    = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_last    = (r_y == YW'(V_ACTIVE - 1));
  assign w_first_pix = (r_x == '0) && (r_y == '0);
  assign w_x_adv     = w_x_last ? '0 : r_x + XW'(1);
  assign w_y_adv     = w_x_last ? (w_y_last ? '0 : r_y + YW'(1)) : r_y;
  // Bars assume H_ACTIVE is a multiple of 8.
  assign w_bar_idx   = 3'(32'(r_x) / (H_ACTIVE / 8));
  assign w_bar       = DATA_WIDTH'(bar_color(w_bar_idx));

  // Ready depends only on registered state and count; r_live holds it low through reset.
  always_comb begin
    w_ready = 1'b0;
    if (r_live && !w_pat) begin
      case (r_state)
        S_WAIT_SOF, S_DROP: w_ready = 1'b1;
        default:            w_ready = !w_full;
      endcase
    end
  end

  assign w_hs = s_valid & w_ready;

  // Next-state, FIFO control, pixel position and output pixel selection.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_set_uf     = 1'b0;
    w_set_se     = 1'b0;
    w_data_next  = r_data;
    w_x_next     = '0;
    w_y_next     = '0;
    if (w_pat) begin
      w_next_state = S_WAIT_SOF;
      w_flush      = 1'b1;
      w_x_next     = r_x;
      w_y_next     = r_y;
      if (video_on) begin
        w_data_next = w_bar;
        w_x_next    = w_x_adv;
        w_y_next    = w_y_adv;
      end
    end else begin
      case (r_state)
        S_WAIT_SOF: begin
          // Only an SOF-marked word opens a frame; everything else is discarded.
          if (w_hs && s_sof) begin
            w_push       = 1'b1;
            w_next_state = S_FILL;
          end
        end
        S_FILL: begin
          w_push = w_hs;
          if (w_vs_rise && !w_empty) w_next_state = S_ACTIVE;
        end
        S_ACTIVE: begin
          w_push   = w_hs;
          w_x_next = r_x;
          w_y_next = r_y;
          if (video_on) begin
            if (w_empty) begin
              // No bypass: a same-cycle push does not rescue an empty pop.
              w_data_next  = UNDERFLOW_COLOR;
              w_set_uf     = 1'b1;
              w_next_state = S_DROP;
            end else begin
              w_pop       = 1'b1;
              w_data_next = w_head[DATA_WIDTH-1:0];
              if (w_head[DATA_WIDTH] != w_first_pix) begin
                w_set_se     = 1'b1;
                w_next_state = S_DROP;
              end else begin
                w_x_next = w_x_adv;
                w_y_next = w_y_adv;
                if (w_x_last && w_y_last) w_next_state = S_FILL;
              end
            end
          end
        end
        default: begin
          w_flush     = 1'b1;
          w_data_next = UNDERFLOW_COLOR;
          if (w_vs_fall) w_next_state = S_WAIT_SOF;
        end
      endcase
    end
  end

  // State, reset-release marker and v_sync history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_WAIT_SOF;
      r_live         <= 1'b0;
      r_vsync_q      <= 1'b1;
      r_frame_active <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_live         <= 1'b1;
      r_vsync_q      <= v_sync;
      r_frame_active <= (w_next_state == S_ACTIVE);
    end
  end

  // FIFO pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  // Pixel position and registered output pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_data <= '0;
    end else begin
      r_x    <= w_x_next;
      r_y    <= w_y_next;
      r_data <= w_data_next;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_set_uf)     r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
      if (w_set_se)     r_sync_err  <= 1'b1;
      else if (err_clr) r_sync_err  <= 1'b0;
    end
  end

  assign s_ready      = w_ready;
  assign data_stream  = r_data;
  assign frame_active = r_frame_active;
  assign underflow    = r_underflow;
  assign sync_err     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_stream_ctrl
// Purpose  : Self-checking bench for vga_stream_ctrl (8x2 frame, 4-deep FIFO).
//            Directed scenarios plus a randomized run against a queue-based
//            reference model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_stream_ctrl;

  localparam int H = 8;
  localparam int V = 2;
  localparam int DEPTH = 4;
  localparam logic [11:0] UF = 12'h000;

  logic        clk, rst_n;
  logic [11:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic        video_on, v_sync, err_clr;
  logic [11:0] data_stream;
  logic        frame_active, underflow, sync_err;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  vga_stream_ctrl #(
    .DATA_WIDTH(12), .FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V),
    .UNDERFLOW_COLOR(UF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sof(s_sof),
    .s_valid(s_valid), .s_ready(s_ready), .video_on(video_on),
    .v_sync(v_sync), .data_stream(data_stream), .frame_active(frame_active),
    .underflow(underflow), .sync_err(sync_err), .err_clr(err_clr)
`ifdef VGA_TEST_PATTERN_EN
    , .pattern_sel(pattern_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Producer queue of {sof, data}; tick() presents its head when drive_prod is set.
  logic [12:0] tx_q[$];
  bit          drive_prod = 1'b1;

  // Reference model: FIFO as a queue, frame position as a linear pixel index.
  localparam int M_WAIT = 0, M_FILL = 1, M_SHOW = 2, M_DROP = 3;
  int          m_mode;
  logic [12:0] m_q[$];
  int          m_pix;
  bit          m_live, m_vsq, m_fa, m_uf, m_se;
  logic [11:0] m_ds;

  function automatic bit m_ready();
    return m_live && (m_mode == M_WAIT || m_mode == M_DROP || m_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit push, rise, fall, su, ss;
    int pre;
    logic [12:0] e;
    if (!rst_n) begin
      m_live = 0; m_mode = M_WAIT; m_q.delete(); m_pix = 0;
      m_ds = '0; m_fa = 0; m_uf = 0; m_se = 0; m_vsq = 1;
      return;
    end
    su = 0; ss = 0;
    push = s_valid && m_ready();
    rise = v_sync && !m_vsq;
    fall = !v_sync && m_vsq;
    pre  = m_q.size();
    case (m_mode)
      M_WAIT: if (push && s_sof) begin m_q.push_back({1'b1, s_data}); m_mode = M_FILL; end
      M_FILL: begin
        if (push) m_q.push_back({s_sof, s_data});
        if (rise && pre != 0) begin m_mode = M_SHOW; m_pix = 0; end
      end
      M_SHOW: begin
        if (video_on) begin
          if (pre == 0) begin
            m_ds = UF; su = 1; m_mode = M_DROP;
          end else begin
            e = m_q.pop_front();
            m_ds = e[11:0];
            if (e[12] != (m_pix == 0)) begin
              ss = 1; m_mode = M_DROP;
            end else begin
              m_pix++;
              if (m_pix == H * V) begin m_pix = 0; m_mode = M_FILL; end
            end
          end
        end
        if (push) m_q.push_back({s_sof, s_data});
      end
      default: begin
        m_q.delete(); m_ds = UF;
        if (fall) m_mode = M_WAIT;
      end
    endcase
    m_uf = su ? 1'b1 : (err_clr ? 1'b0 : m_uf);
    m_se = ss ? 1'b1 : (err_clr ? 1'b0 : m_se);
    m_fa = (m_mode == M_SHOW);
    m_vsq = v_sync;
    m_live = 1;
  endtask

  task automatic tick();
    logic rdy;
    if (drive_prod) begin
      s_valid = (tx_q.size() != 0);
      if (tx_q.size() != 0) {s_sof, s_data} = tx_q[0];
    end
    rdy = s_ready;
    @(posedge clk);
    model_step();
    if (drive_prod && s_valid && rdy && tx_q.size() != 0) tx_q.delete(0);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; s_valid = 0; s_sof = 0; s_data = '0; video_on = 0;
    v_sync = 1; err_clr = 0; drive_prod = 1; tx_q.delete();
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 0;
`endif
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic load_frame(input int n, input int extra_sof);
    for (int i = 1; i <= n; i++) tx_q.push_back({(i == 1 || i == extra_sof), 12'(i)});
  endtask

  task automatic vsync_pulse();
    v_sync = 0; tick(); tick();
    v_sync = 1; tick();
  endtask

  task automatic test_reset();
    rst_n = 0; drive_prod = 0; s_valid = 1; s_sof = 1; s_data = 12'hABC;
    video_on = 1; v_sync = 1; err_clr = 0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 0;
`endif
    tick(); tick(); tick();
    total++; if (data_stream !== 12'h000) begin bad++; $display("FAIL rst_data: got %h want 000", data_stream); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    total++; if ({frame_active, underflow, sync_err} !== 3'b000)
      begin bad++; $display("FAIL rst_flags: got %b want 000", {frame_active, underflow, sync_err}); end
    rst_n = 1; s_valid = 0; video_on = 0;
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_normal_frame();
    int p;
    apply_reset();
    load_frame(16, 0);
    repeat (6) tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL nf_full: got %b want 0", s_ready); end
    vsync_pulse();
    total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL nf_fa: got %b want 1", frame_active); end
    p = 0;
    for (int ln = 0; ln < V; ln++) begin
      for (int c = 0; c < H; c++) begin
        video_on = 1; tick(); p++;
        total++; if (data_stream !== 12'(p)) begin bad++; $display("FAIL nf_pix%0d: got %h want %h", p, data_stream, 12'(p)); end
      end
      video_on = 0;
      if (ln == 0) begin
        tick(); tick();
        total++; if (data_stream !== 12'h008) begin bad++; $display("FAIL nf_hold: got %h want 008", data_stream); end
      end
    end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL nf_fa_end: got %b want 0", frame_active); end
    total++; if ({underflow, sync_err} !== 2'b00) begin bad++; $display("FAIL nf_flags: got %b want 00", {underflow, sync_err}); end
  endtask

  task automatic test_underflow();
    logic [11:0] exp;
    apply_reset();
    load_frame(5, 0);
    repeat (6) tick();
    vsync_pulse();
    for (int p = 1; p <= 16; p++) begin
      video_on = 1; tick();
      exp = (p <= 5) ? 12'(p) : UF;
      total++; if (data_stream !== exp) begin bad++; $display("FAIL uf_pix%0d: got %h want %h", p, data_stream, exp); end
      if (p == 6) begin
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", underflow); end
      end
    end
    video_on = 0;
    tx_q.push_back({1'b1, 12'h055});
    tick(); tick();
    total++; if ({frame_active, s_ready} !== 2'b01) begin bad++; $display("FAIL uf_drop: got %b want 01", {frame_active, s_ready}); end
    total++; if (data_stream !== UF) begin bad++; $display("FAIL uf_drop_data: got %h want %h", data_stream, UF); end
    v_sync = 0; tick();
    v_sync = 1; tick();
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    err_clr = 1; tick(); err_clr = 0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clr: got %b want 0", underflow); end
  endtask

  task automatic test_sync_err();
    logic [11:0] exp;
    apply_reset();
    load_frame(16, 4);
    repeat (6) tick();
    vsync_pulse();
    for (int p = 1; p <= 8; p++) begin
      video_on = 1; err_clr = (p == 4); tick();
      exp = (p <= 4) ? 12'(p) : UF;
      total++; if (data_stream !== exp) begin bad++; $display("FAIL se_pix%0d: got %h want %h", p, data_stream, exp); end
      if (p == 4) begin
        total++; if ({sync_err, underflow} !== 2'b10) begin bad++; $display("FAIL se_set_wins: got %b want 10", {sync_err, underflow}); end
      end
    end
    video_on = 0; err_clr = 0;
    tick();
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL se_sticky: got %b want 1", sync_err); end
    err_clr = 1; tick(); err_clr = 0;
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL se_clr: got %b want 0", sync_err); end
  endtask

  task automatic test_full();
    apply_reset();
    load_frame(10, 0);
    repeat (8) tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fu_ready0: got %b want 0", s_ready); end
    vsync_pulse();
    video_on = 1; tick();
    total++; if ({data_stream, s_ready} !== {12'h001, 1'b1}) begin bad++; $display("FAIL fu_pop1: got %h/%b want 001/1", data_stream, s_ready); end
    tick();
    total++; if ({data_stream, s_ready} !== {12'h002, 1'b1}) begin bad++; $display("FAIL fu_pushpop: got %h/%b want 002/1", data_stream, s_ready); end
    video_on = 0; tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fu_refull: got %b want 0", s_ready); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    apply_reset();
    pattern_sel = 1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pat_ready: got %b want 0", s_ready); end
    for (int x = 0; x < 8; x++) begin
      video_on = 1; tick();
      total++; if (data_stream !== bars[x]) begin bad++; $display("FAIL pat_x%0d: got %h want %h", x, data_stream, bars[x]); end
    end
    video_on = 0; pattern_sel = 0;
  endtask
`endif

  task automatic test_random();
    int k, cyc;
    logic rdy;
    apply_reset();
    drive_prod = 0; k = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      s_valid  = ($urandom_range(0, 9) < 8);
      s_data   = 12'($urandom);
      s_sof    = ((k % (H * V)) == 0) ^ ($urandom_range(0, 39) == 0);
      video_on = ($urandom_range(0, 3) != 0);
      v_sync   = ((cyc % 48) >= 3);
      err_clr  = ($urandom_range(0, 19) == 0);
      rst_n    = ($urandom_range(0, 999) != 0);
      rdy = s_ready;
      tick();
      if (s_valid && rdy) k++;
      total++; if (data_stream !== m_ds) begin bad++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, data_stream, m_ds); end
      total++; if (s_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, s_ready, m_ready()); end
      total++; if (frame_active !== m_fa) begin bad++; $display("FAIL rnd_fa c%0d: got %b want %b", cyc, frame_active, m_fa); end
      total++; if (underflow !== m_uf) begin bad++; $display("FAIL rnd_uf c%0d: got %b want %b", cyc, underflow, m_uf); end
      total++; if (sync_err !== m_se) begin bad++; $display("FAIL rnd_se c%0d: got %b want %b", cyc, sync_err, m_se); end
    end
    rst_n = 1; drive_prod = 1; err_clr = 0; video_on = 0; v_sync = 1;
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_underflow();
    test_sync_err();
    test_full();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
